// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: two read ports, two write ports and the issue/scoreboard signals.
interface reg_file_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 6
);
   logic [ADDR_W-1:0] ra1;
   logic [ADDR_W-1:0] ra2;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic              rd1_busy;
   logic              rd2_busy;
   logic              we0;
   logic [ADDR_W-1:0] wa0;
   logic [DATA_W-1:0] wd0;
   logic              we1;
   logic [ADDR_W-1:0] wa1;
   logic [DATA_W-1:0] wd1;
   logic              set_busy;
   logic [ADDR_W-1:0] busy_addr;
   logic [ADDR_W:0]   busy_cnt;

   modport master (
      output ra1, ra2, we0, wa0, wd0, we1, wa1, wd1, set_busy, busy_addr,
      input  rd1, rd2, rd1_busy, rd2_busy, busy_cnt
   );

   modport slave (
      input  ra1, ra2, we0, wa0, wd0, we1, wa1, wd1, set_busy, busy_addr,
      output rd1, rd2, rd1_busy, rd2_busy, busy_cnt
   );
endinterface

// File: rtl/reg_file_sb.sv
// Two-read / two-write register file with per-register pending bits and a registered busy count.
module reg_file_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 6,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic          clk,
   input  logic          rst,
   reg_file_sb_if.slave  bus
);

   localparam int                DEPTH     = 2 ** ADDR_W;
   localparam bit                ZR_EN     = (ZERO_REG != 32'sd0);
   localparam bit                BYP_EN    = (BYPASS != 32'sd0);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [DEPTH-1:0]  busy_r;
   logic [DEPTH-1:0]  set_s;
   logic [DEPTH-1:0]  clr_s;
   logic [DEPTH-1:0]  busy_nxt_s;
   logic [ADDR_W:0]   cnt_r;
   logic              wr0_s;
   logic              wr1_s;
   logic              z1_s;
   logic              z2_s;
   logic              h01_s;
   logic              h11_s;
   logic              h02_s;
   logic              h12_s;

   function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
      logic [ADDR_W:0] c;
      c = {(ADDR_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         c = c + {{ADDR_W{1'b0}}, v[i]};
      end
      return c;
   endfunction

   function automatic logic fwd_hit(input logic we, input logic [ADDR_W-1:0] wa,
                                    input logic [ADDR_W-1:0] ra);
      return BYP_EN && we && (wa == ra);
   endfunction

   // Data commit enables: port 1 loses to port 0 on the same address; r0 may be hardwired.
   always_comb begin
      wr0_s = bus.we0 && !(ZR_EN && (bus.wa0 == ZERO_ADDR));
      wr1_s = bus.we1 && !(ZR_EN && (bus.wa1 == ZERO_ADDR))
                      && !(bus.we0 && (bus.wa0 == bus.wa1));
   end

   // Next pending vector: any write clears its address, issue sets, set beats clear.
   always_comb begin
      set_s = {DEPTH{1'b0}};
      clr_s = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         clr_s[i] = (bus.we0 && (bus.wa0 == ADDR_W'(i))) || (bus.we1 && (bus.wa1 == ADDR_W'(i)));
         set_s[i] = bus.set_busy && (bus.busy_addr == ADDR_W'(i)) && !(ZR_EN && (i == 32'sd0));
      end
      busy_nxt_s = set_s | (busy_r & ~clr_s);
   end

   // Combinational read ports with optional write-first forwarding.
   always_comb begin
      z1_s  = ZR_EN && (bus.ra1 == ZERO_ADDR);
      z2_s  = ZR_EN && (bus.ra2 == ZERO_ADDR);
      h01_s = fwd_hit(bus.we0, bus.wa0, bus.ra1);
      h11_s = fwd_hit(bus.we1, bus.wa1, bus.ra1);
      h02_s = fwd_hit(bus.we0, bus.wa0, bus.ra2);
      h12_s = fwd_hit(bus.we1, bus.wa1, bus.ra2);
      bus.rd1 = z1_s ? {DATA_W{1'b0}} : h01_s ? bus.wd0 : h11_s ? bus.wd1 : mem_r[bus.ra1];
      bus.rd2 = z2_s ? {DATA_W{1'b0}} : h02_s ? bus.wd0 : h12_s ? bus.wd1 : mem_r[bus.ra2];
      bus.rd1_busy = !z1_s && !h01_s && !h11_s && busy_r[bus.ra1];
      bus.rd2_busy = !z2_s && !h02_s && !h12_s && busy_r[bus.ra2];
   end

   assign bus.busy_cnt = cnt_r;

   // Register storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
      end else begin
         if (wr0_s) begin
            mem_r[bus.wa0] <= bus.wd0;
         end
         if (wr1_s) begin
            mem_r[bus.wa1] <= bus.wd1;
         end
      end
   end

   // Scoreboard bits and their population count, both registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= {DEPTH{1'b0}};
         cnt_r  <= {(ADDR_W+1){1'b0}};
      end else begin
         busy_r <= busy_nxt_s;
         cnt_r  <= popcount(busy_nxt_s);
      end
   end

endmodule
